load_store_unit: RTL

- Sits directly upstream of the 256x32 word memory. Converts CPU MEM-stage byte/halfword/word load and store requests into word-wide memory accesses.
- Loads: alignment and sign/zero extension.
- Sub-word stores: read-modify-write.
- Detects misaligned accesses and reports them without touching memory.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/load_store_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, lane masks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package load_store_unit_pkg;

    // Access size encodings as presented by the CPU MEM stage.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Sequencer states; memory enables decode directly from these.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } lsu_state_e;

    // Right-justified lane masks, shifted into place by the byte offset.
    localparam logic [31:0] LANE_MASK_BYTE = 32'h0000_00FF;
    localparam logic [31:0] LANE_MASK_HALF = 32'h0000_FFFF;
    localparam logic [31:0] LANE_MASK_WORD = 32'hFFFF_FFFF;

    // An access is legal when it does not straddle its natural boundary.
    function automatic logic access_legal(input logic [1:0] size, input logic [1:0] offset);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~offset[0];
            SZ_WORD: ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge (little-endian).
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] mem_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;

    // Shift the addressed lane down for loads, and splice new lanes in for stores.
    always_comb begin
        shamt       = {offset_i, 3'b000};
        shifted     = mem_word_i >> shamt;
        lane_mask   = LANE_MASK_WORD;
        load_data_o = mem_word_i;
        case (size_i)
            SZ_BYTE: begin
                lane_mask   = LANE_MASK_BYTE;
                load_data_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                lane_mask   = LANE_MASK_HALF;
                load_data_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                lane_mask   = LANE_MASK_WORD;
                load_data_o = mem_word_i;
            end
        endcase
        merge_data_o = (mem_word_i & ~(lane_mask << shamt))
                     | ((store_data_i & lane_mask) << shamt);
    end

endmodule

// File: rtl/load_store_unit.sv
// CPU byte/half/word loads and stores onto a word-wide level-sensitive memory (RMW for sub-word stores).
// Latency accept->done: load 2, word store 2, sub-word store 3, error 1 cycle.
// Backpressure: busy high while an access is in flight; req is ignored (not queued) until IDLE.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W+1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic              sign_ext_q;
    logic [1:0]        offset_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    lsu_lane_align u_lane_align (
        .offset_i     (offset_q),
        .size_i       (size_q),
        .sign_ext_i   (sign_ext_q),
        .mem_word_i   (mem_rdata),
        .store_data_i (wdata_q),
        .load_data_o  (load_data),
        .merge_data_o (merge_data)
    );

    // Access sequencer: capture in IDLE, read and/or write one cycle each, then a one-cycle response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            sign_ext_q  <= 1'b0;
            offset_q    <= 2'b00;
            wdata_q     <= 32'h0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q       <= we;
                        size_q     <= size;
                        sign_ext_q <= sign_ext;
                        offset_q   <= addr[1:0];
                        wdata_q    <= wdata;
                        mem_addr_q <= addr[ADDR_W+1:2];
                        if (!access_legal(size, addr[1:0])) begin
                            // Illegal accesses never enable the memory.
                            err_q   <= 1'b1;
                            state_q <= ST_RESP;
                        end else begin
                            err_q <= 1'b0;
                            if (we && size == SZ_WORD) begin
                                mem_wdata_q <= wdata;
                                state_q     <= ST_WR;
                            end else begin
                                // Loads and sub-word stores both need the current word first.
                                state_q <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (we_q) begin
                        mem_wdata_q <= merge_data;
                        state_q     <= ST_WR;
                    end else begin
                        rdata_q <= load_data;
                        state_q <= ST_RESP;
                    end
                end
                ST_WR:   state_q <= ST_RESP;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Enables and status come straight off the state register so the memory never sees glitches.
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_RESP);
    assign mem_read  = (state_q == ST_RD);
    assign mem_write = (state_q == ST_WR);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
